// File: rtl/regfile_wr_arbiter_pkg.sv
// Shared widths, the x0 index and grant encodings for the register-file write arbiter.
package regfile_wr_arbiter_pkg;

  localparam int XLEN_DEF = 32;
  localparam int AW_DEF   = 5;
  localparam int X0_ADDR  = 0;

  typedef enum logic [1:0] {
    GNT_NONE = 2'b00,
    GNT_REQ0 = 2'b01,
    GNT_REQ1 = 2'b10
  } grant_e;

  // last_grant encoding: which requester won the most recent transfer
  localparam logic LG_REQ0 = 1'b0;
  localparam logic LG_REQ1 = 1'b1;

endpackage

// File: rtl/regfile_wr_arbiter_pick.sv
// Combinational 2-way writeback picker, zero latency; returns a one-hot grant, never without its valid.
module wb_arb_pick
  import regfile_wr_arbiter_pkg::*;
#(
  parameter int RR = 0
) (
  input  logic       valid0,
  input  logic       valid1,
  input  logic       last_grant,
  input  logic       force1,
  output logic [1:0] grant
);

  always_comb begin
    grant = GNT_NONE;
    if (valid0 && valid1) begin
      if (RR != 0) begin
        grant = (last_grant == LG_REQ1) ? GNT_REQ0 : GNT_REQ1;
      end else begin
        grant = force1 ? GNT_REQ1 : GNT_REQ0;
      end
    end else if (valid0) begin
      grant = GNT_REQ0;
    end else if (valid1) begin
      grant = GNT_REQ1;
    end
  end

endmodule

// File: rtl/regfile_wr_arbiter.sv
// Shares the register-file write port between two writeback sources; 1-cycle registered write.
// Readies are combinational from valids and state; the register file never backpressures.
module regfile_wr_arbiter
  import regfile_wr_arbiter_pkg::*;
#(
  parameter int XLEN     = XLEN_DEF,
  parameter int AW       = AW_DEF,
  parameter int RR       = 0,
  parameter int MAX_WAIT = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req0_valid,
  output logic            req0_ready,
  input  logic [AW-1:0]   req0_addr,
  input  logic [XLEN-1:0] req0_data,
  input  logic            req1_valid,
  output logic            req1_ready,
  input  logic [AW-1:0]   req1_addr,
  input  logic [XLEN-1:0] req1_data,
  output logic            wr_en,
  output logic [AW-1:0]   wr_addr,
  output logic [XLEN-1:0] wr_data,
  output logic [1:0]      wr_src
);

  localparam logic [3:0]    MAX_W = 4'(MAX_WAIT);
  localparam logic [AW-1:0] X0    = AW'(X0_ADDR);

  logic            last_grant;
  logic [3:0]      wait_cnt;
  logic            force1;
  logic [1:0]      grant;
  logic            xfer;
  logic [AW-1:0]   sel_addr;
  logic [XLEN-1:0] sel_data;

  assign force1 = (RR == 0) && (wait_cnt == MAX_W);

  wb_arb_pick #(.RR(RR)) u_pick (
    .valid0     (req0_valid),
    .valid1     (req1_valid),
    .last_grant (last_grant),
    .force1     (force1),
    .grant      (grant)
  );

  // Readies are held low for as long as reset is asserted
  assign req0_ready = rst & grant[0];
  assign req1_ready = rst & grant[1];
  assign xfer       = req0_ready | req1_ready;

  assign sel_addr = req1_ready ? req1_addr : req0_addr;
  assign sel_data = req1_ready ? req1_data : req0_data;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_grant <= LG_REQ1;
      wait_cnt   <= '0;
    end else begin
      if (xfer) begin
        last_grant <= req1_ready ? LG_REQ1 : LG_REQ0;
      end
      if (req1_valid && !req1_ready) begin
        wait_cnt <= (wait_cnt == MAX_W) ? MAX_W : wait_cnt + 4'd1;
      end else begin
        wait_cnt <= '0;
      end
    end
  end

  // Async reset drops a pending write immediately, before the register file samples it
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      wr_src  <= GNT_NONE;
    end else if (xfer) begin
      wr_en   <= (sel_addr != X0);
      wr_addr <= sel_addr;
      wr_data <= sel_data;
      wr_src  <= {req1_ready, req0_ready};
    end else begin
      wr_en   <= 1'b0;
      wr_src  <= GNT_NONE;
    end
  end

endmodule
